// File: rtl/pipe_chain.sv
// pipe_chain: linear chain of STAGES register stages with per-stage hold and
// flush, load-use hazard detection between stages 0 and 1, and saturating
// stall/flush event counters.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid        a new word is offered to stage 0
//   in_data         the offered word (WIDTH bits)
//   in_ready        combinational: stage 0 takes the offered word this edge
//   hold_i          per-stage freeze request
//   flush_i         per-stage kill (wins over hold)
//   src1, src2      source register addresses of the stage-0 instruction
//   src_en          enables for src1 (bit 0) and src2 (bit 1)
//   stage_valid     valid bit per stage
//   stage_data      stage k contents at bits [k*WIDTH +: WIDTH]
//   load_use        combinational: load-use hazard between stages 1 and 0
//   stall_cnt       saturating count of cycles with in_valid & !in_ready
//   flush_cnt       saturating count of cycles with any flush_i bit set
module pipe_chain #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned STAGES   = 4,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned LD_BIT   = 40,
   parameter int unsigned DST_LSB  = 49,
   parameter int unsigned COLLAPSE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   input  logic [STAGES-1:0]         hold_i,
   input  logic [STAGES-1:0]         flush_i,
   input  logic [ADDR_W-1:0]         src1,
   input  logic [ADDR_W-1:0]         src2,
   input  logic [1:0]                src_en,
   output logic [STAGES-1:0]         stage_valid,
   output logic [STAGES*WIDTH-1:0]   stage_data,
   output logic                      load_use,
   output logic [15:0]               stall_cnt,
   output logic [15:0]               flush_cnt
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Packed so element k lands at bits [k*WIDTH +: WIDTH] of stage_data.
   logic [STAGES-1:0][WIDTH-1:0] data_q;
   logic [STAGES-1:0]            valid_q;
   logic [CNT_W-1:0]             stall_cnt_q;
   logic [CNT_W-1:0]             flush_cnt_q;

   logic [STAGES-1:0]            stall;
   logic [STAGES-1:0]            keep;
   logic [ADDR_W-1:0]            dst1;
   logic                         stall_hit;
   logic                         flush_hit;

   // Back-pressure chain, computed from the last stage toward stage 0.
   always_comb begin : stall_chain
      logic chain;
      chain = 1'b0;
      stall = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (k == STAGES - 1) begin
            chain = hold_i[k];
         end else if (COLLAPSE != 0) begin
            chain = hold_i[k] | (chain & valid_q[k+1]);
         end else begin
            chain = hold_i[k] | chain;
         end
         stall[k] = chain;
      end
   end

   // Load in stage 1 whose destination feeds the stage-0 instruction.
   always_comb begin : hazard
      dst1     = data_q[1][DST_LSB +: ADDR_W];
      load_use = valid_q[0] & valid_q[1] & data_q[1][LD_BIT] &
                 ((src_en[0] & (src1 == dst1)) | (src_en[1] & (src2 == dst1)));
      in_ready = ~stall[0] & ~load_use;
   end

   // Per-stage "keep contents" decision. In collapse mode an empty stage that
   // is only stalled by downstream pressure still accepts its upstream word,
   // since holding a bubble protects nothing. Stage 0 always obeys in_ready so
   // a dropped word is never captured.
   always_comb begin : keep_logic
      keep    = stall;
      keep[0] = stall[0] | load_use;
      for (int k = 1; k < STAGES; k++) begin
         if ((COLLAPSE != 0) && !valid_q[k] && !hold_i[k]) begin
            keep[k] = 1'b0;
         end
      end
   end

   // Stage registers: flush beats keep, keep beats load.
   always_ff @(posedge clk or posedge rst) begin : stages
      if (rst) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         if (flush_i[0]) begin
            valid_q[0] <= 1'b0;
         end else if (!keep[0]) begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (flush_i[k]) begin
               valid_q[k] <= 1'b0;
            end else if (!keep[k]) begin
               data_q[k]  <= data_q[k-1];
               // A bubble enters behind an upstream stage that is holding.
               valid_q[k] <= valid_q[k-1] & ~keep[k-1];
            end
         end
      end
   end

   assign stall_hit = in_valid & ~in_ready;
   assign flush_hit = |flush_i;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin : counters
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_hit && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_hit && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stage_valid = valid_q;
   assign stage_data  = data_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
